// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared opcodes, ALU codes, FSM states and select encodings for the
// RV32I multi-cycle controller.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] TC_NONE     = 2'd0;
    localparam logic [1:0] TC_ILLEGAL  = 2'd1;
    localparam logic [1:0] TC_FETCH_TO = 2'd2;
    localparam logic [1:0] TC_DATA_TO  = 2'd3;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    function automatic logic opcode_valid(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

endpackage

// File: rtl/rv32i_alu_dec.sv
// rv32i_alu_dec: maps opcode/funct3/funct7[5] to the ALU operation code.
module rv32i_alu_dec
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_ctrl
);

    logic [3:0] alu_op;

    always_comb begin
        case (funct3)
            3'b000:  alu_op = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
        // Branches subtract so alu_zero reflects rs1 == rs2.
        alu_ctrl = (opcode == OP_R || opcode == OP_I) ? alu_op :
                   (opcode == OP_LUI)                 ? ALU_PASSB :
                   (opcode == OP_BRANCH)              ? ALU_SUB : ALU_ADD;
    end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath
// enables and selects, with illegal-opcode and memory-timeout traps.
module rv32i_mc_ctrl
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_dbg
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;
    logic [3:0]      dec_ctrl;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            taken, timed_out, alu_on;

    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign state_dbg  = state_q;

    rv32i_alu_dec u_alu_dec (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_b5 (instr[30]),
        .alu_ctrl  (dec_ctrl)
    );

    // funct3[0] inverts the base condition: BNE/BGE/BGEU.
    assign taken     = funct3[0] ^ (funct3[2] ? (funct3[1] ? alu_ltu : alu_lt) : alu_zero);
    // This cycle is the last allowed wait; a concurrent mem_ready takes priority.
    assign timed_out = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == TO_LIM);

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        alu_on       = state_q inside {ST_EXEC, ST_MEM, ST_WB};
        alu_src_a    = alu_on && opcode == OP_AUIPC;
        alu_src_b    = alu_on && (opcode inside {OP_I, OP_LOAD, OP_STORE, OP_JALR, OP_LUI, OP_AUIPC});
        alu_ctrl     = (state_q == ST_RESET) ? 4'b0000 : alu_on ? dec_ctrl : ALU_ADD;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = TC_FETCH_TO;
                end
            end
            ST_DECODE: begin
                state_d = opcode_valid(opcode) ? ST_EXEC : ST_TRAP;
                cause_d = opcode_valid(opcode) ? cause_q : TC_ILLEGAL;
            end
            ST_EXEC: begin
                if (opcode == OP_BRANCH && funct3[2:1] == 2'b01) begin
                    state_d = ST_TRAP;
                    cause_d = TC_ILLEGAL;
                end else if (opcode == OP_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = taken ? PC_IMM : PC_PLUS4;
                    state_d = ST_FETCH;
                end else begin
                    state_d = (opcode == OP_LOAD || opcode == OP_STORE) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_STORE);
                if (mem_ready) begin
                    pc_we   = mem_we;
                    state_d = mem_we ? ST_FETCH : ST_WB;
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = TC_DATA_TO;
                end
            end
            ST_WB: begin
                reg_we  = (instr[11:7] != 5'd0);
                pc_we   = 1'b1;
                wb_sel  = (opcode == OP_LOAD) ? WB_MEM :
                          (opcode == OP_JAL || opcode == OP_JALR) ? WB_PC4 : WB_ALU;
                pc_sel  = (opcode == OP_JAL) ? PC_IMM : (opcode == OP_JALR) ? PC_ALU : PC_PLUS4;
                state_d = ST_FETCH;
            end
            default: state_d = state_q;
        endcase
        cnt_d = (state_d != state_q) ? '0 : (mem_req && !mem_ready) ? cnt_q + TO_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            cause_q <= TC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// tb_rv32i_mc_ctrl: directed scoreboard bench; each cycle's expected output bundle
// is queued with the stimulus and compared at the following falling edge.
module tb_rv32i_mc_ctrl;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b1;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
    logic        alu_src_a, alu_src_b, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [3:0]  alu_ctrl;
    logic [2:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;
    exp_t scb[$];

    rv32i_mc_ctrl #(.MEM_TIMEOUT(8), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .alu_ltu(alu_ltu), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] ev(input logic [2:0] st, input logic req, we, asel, irwe, pcwe,
                                       input logic [1:0] psel, input logic rwe, input logic [1:0] wsel,
                                       input logic sa, sbv, input logic [3:0] ac,
                                       input logic tr, input logic [1:0] tc);
        return {st, req, we, asel, irwe, pcwe, psel, rwe, wsel, sa, sbv, ac, tr, tc};
    endfunction

    function automatic logic [21:0] e_rst();
        return ev(3'd0, N, N, N, N, N, 2'd0, N, 2'd0, N, N, 4'b0000, N, 2'd0);
    endfunction
    function automatic logic [21:0] e_fet(input logic rdy);
        return ev(3'd1, Y, N, N, rdy, N, 2'd0, N, 2'd0, N, N, ADD, N, 2'd0);
    endfunction
    function automatic logic [21:0] e_dec();
        return ev(3'd2, N, N, N, N, N, 2'd0, N, 2'd0, N, N, ADD, N, 2'd0);
    endfunction
    function automatic logic [21:0] e_trap(input logic [1:0] tc);
        return ev(3'd6, N, N, N, N, N, 2'd0, N, 2'd0, N, N, ADD, Y, tc);
    endfunction
    function automatic logic [21:0] e_ld_mem();
        return ev(3'd4, Y, N, Y, N, N, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0);
    endfunction

    task automatic compare();
        exp_t e;
        logic [21:0] obs;
        e = scb.pop_front();
        obs = {state_dbg, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel,
               alu_src_a, alu_src_b, alu_ctrl, trap, trap_cause};
        checks++;
        assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    task automatic step(input string tag, input logic [21:0] e);
        scb.push_back('{tag, e});
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        step({tag, "_held"}, e_rst());
        rst_n = 1'b1;
        step({tag, "_release"}, e_rst());
    endtask

    task automatic fd(input string tag, input logic [31:0] ins);
        instr = ins;
        step({tag, "_fetch"}, e_fet(Y));
        step({tag, "_decode"}, e_dec());
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("reset");

        fd("addi", 32'h00500093);
        step("addi_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));
        step("addi_wb",   ev(3'd5, N, N, N, N, Y, 2'd0, Y, 2'd0, N, Y, ADD, N, 2'd0));

        fd("sub", 32'h40208133);
        step("sub_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, N, SUB, N, 2'd0));
        step("sub_wb",   ev(3'd5, N, N, N, N, Y, 2'd0, Y, 2'd0, N, N, SUB, N, 2'd0));

        fd("addi_x0", 32'h00100013);
        step("addi_x0_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));
        step("addi_x0_wb",   ev(3'd5, N, N, N, N, Y, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));

        alu_zero = 1'b1;
        fd("beq_t", 32'h00000463);
        step("beq_t_exec", ev(3'd3, N, N, N, N, Y, 2'd1, N, 2'd0, N, N, SUB, N, 2'd0));
        alu_zero = 1'b0;
        fd("beq_nt", 32'h00000463);
        step("beq_nt_exec", ev(3'd3, N, N, N, N, Y, 2'd0, N, 2'd0, N, N, SUB, N, 2'd0));
        alu_ltu = 1'b1;
        fd("bltu_t", 32'h00006463);
        step("bltu_t_exec", ev(3'd3, N, N, N, N, Y, 2'd1, N, 2'd0, N, N, SUB, N, 2'd0));
        alu_ltu = 1'b0;
        alu_lt = 1'b1;
        fd("bge_nt", 32'h00005463);
        step("bge_nt_exec", ev(3'd3, N, N, N, N, Y, 2'd0, N, 2'd0, N, N, SUB, N, 2'd0));
        alu_lt = 1'b0;

        fd("lw", 32'h0000a183);
        step("lw_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mem_wait", e_ld_mem());
        mem_ready = 1'b1;
        step("lw_mem_ready", e_ld_mem());
        step("lw_wb", ev(3'd5, N, N, N, N, Y, 2'd0, Y, 2'd1, N, Y, ADD, N, 2'd0));

        fd("sw", 32'h0020a023);
        step("sw_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));
        step("sw_mem",  ev(3'd4, Y, Y, Y, N, Y, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));

        fd("jal", 32'h008000ef);
        step("jal_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, N, ADD, N, 2'd0));
        step("jal_wb",   ev(3'd5, N, N, N, N, Y, 2'd1, Y, 2'd2, N, N, ADD, N, 2'd0));
        fd("jalr", 32'h000080e7);
        step("jalr_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));
        step("jalr_wb",   ev(3'd5, N, N, N, N, Y, 2'd2, Y, 2'd2, N, Y, ADD, N, 2'd0));
        fd("lui", 32'h123450b7);
        step("lui_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, Y, 4'b1111, N, 2'd0));
        step("lui_wb",   ev(3'd5, N, N, N, N, Y, 2'd0, Y, 2'd0, N, Y, 4'b1111, N, 2'd0));
        fd("auipc", 32'h00001097);
        step("auipc_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, Y, Y, ADD, N, 2'd0));
        step("auipc_wb",   ev(3'd5, N, N, N, N, Y, 2'd0, Y, 2'd0, Y, Y, ADD, N, 2'd0));

        // Ready on the limit cycle must still complete the fetch.
        instr = 32'h00500093;
        mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) step("fetch_wait", e_fet(N));
        mem_ready = 1'b1;
        step("fetch_ready_at_limit", e_fet(Y));
        step("decode_after_limit", e_dec());
        step("exec_after_limit", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));
        step("wb_after_limit",   ev(3'd5, N, N, N, N, Y, 2'd0, Y, 2'd0, N, Y, ADD, N, 2'd0));

        fd("illegal", 32'h00000000);
        for (int i = 0; i < 3; i++) step("illegal_trap", e_trap(2'd1));
        do_reset("reset_after_illegal");

        fd("bad_branch", 32'h00002463);
        step("bad_branch_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, N, SUB, N, 2'd0));
        step("bad_branch_trap", e_trap(2'd1));
        do_reset("reset_after_bad_branch");

        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) step("fetch_to_wait", e_fet(N));
        step("fetch_to_trap", e_trap(2'd2));
        mem_ready = 1'b1;
        step("fetch_to_trap_hold", e_trap(2'd2));
        do_reset("reset_after_fetch_to");

        fd("lw_to", 32'h0000a183);
        step("lw_to_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) step("lw_to_wait", e_ld_mem());
        step("data_to_trap", e_trap(2'd3));
        mem_ready = 1'b1;
        do_reset("reset_after_data_to");

        fd("lw_rst", 32'h0000a183);
        step("lw_rst_exec", ev(3'd3, N, N, N, N, N, 2'd0, N, 2'd0, N, Y, ADD, N, 2'd0));
        mem_ready = 1'b0;
        step("lw_rst_mem", e_ld_mem());
        #2;
        rst_n = 1'b0;
        #1;
        scb.push_back('{"async_reset_mid_mem", e_rst()});
        compare();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("reset_release_after_mem", e_rst());
        mem_ready = 1'b1;
        step("fetch_after_async_reset", e_fet(Y));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multi-cycle control sequencer for the RV32I datapath (pc, regfile, imm_gen, alu). It replaces the free-running pc+4 / always-write scheme with a FETCH→DECODE→EXEC→MEM→WB state machine. It drives every datapath enable and mux select and handshakes with a single shared instruction/data memory port. It also traps on illegal opcodes and on memory timeouts.

Parameters:
MEM_TIMEOUT, 255, max cycles mem_req may wait for mem_ready before trapping; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
instr  input  32  current instruction register contents
alu_zero  input  1  ALU result == 0
alu_lt  input  1  signed a<b from the datapath comparator
alu_ltu  input  1  unsigned a<b
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request
mem_we  output  1  store request (valid only with mem_req)
mem_addr_sel  output  1  0=pc, 1=alu_out
ir_we  output  1  load instruction register
pc_we  output  1  update pc
pc_sel  output  2  0=pc+4, 1=pc+imm, 2=(alu_out & ~1)
reg_we  output  1  regfile write
wb_sel  output  2  0=alu_out, 1=mem rdata, 2=pc+4
alu_src_a  output  1  0=rs1, 1=pc
alu_src_b  output  1  0=rs2, 1=imm
alu_ctrl  output  4  ALU operation
trap  output  1  sticky halt flag
trap_cause  output  2  0=none, 1=illegal opcode, 2=fetch timeout, 3=data timeout
state_dbg  output  3  current state encoding

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset response: rst_n low forces state RESET and clears the timeout counter, trap and trap_cause. All outputs are 0 while in RESET. Assertion mid-transaction drops mem_req combinationally. The first cycle after release is RESET, then FETCH.
- Output timing: outputs are combinational from the registered state and instr. Default value of every output is 0. alu_ctrl defaults to 0010 (ADD).
- FETCH: mem_req=1, mem_addr_sel=0. Hold until mem_ready. On the mem_ready cycle ir_we=1 → DECODE.
- DECODE: one cycle, no enables. Valid opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Any other opcode → TRAP with cause 1.
- EXEC, R/I-ALU: alu_ctrl from funct3/funct7[5]. SUB and SRA/SRAI are decoded when funct7[5]=1; an I-type ADDI never subtracts. alu_src_b=1 for I-type → WB.
- EXEC, LUI: alu_ctrl=1111 (pass b), alu_src_b=1 → WB.
- EXEC, AUIPC: alu_src_a=1, alu_src_b=1, ADD → WB.
- EXEC, load/store: ADD, alu_src_b=1 → MEM.
- EXEC, branch: pc_we=1. pc_sel=1 if the condition holds, else 0 → FETCH.
  - BEQ uses alu_zero, BNE uses !alu_zero.
  - BLT/BGE use alu_lt; BLTU/BGEU use alu_ltu.
  - funct3 010/011 is illegal → TRAP cause 1.
- EXEC, JAL/JALR: JALR computes rs1+imm → WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for stores. Wait for mem_ready. On ready: load → WB; store asserts pc_we with pc_sel=0 → FETCH.
- WB: reg_we=1 unless rd==0. pc_we=1 → FETCH.
  - Loads: wb_sel=1. ALU/LUI/AUIPC: wb_sel=0.
  - JAL: wb_sel=2, pc_sel=1. JALR: wb_sel=2, pc_sel=2. All others: pc_sel=0.
- Latency with zero-wait memory, counted from FETCH entry to next FETCH: ALU/LUI/AUIPC/JAL/JALR 4 cycles, load 5, store 4, branch 3.
- Timeout counter: clears on entering FETCH or MEM and increments each cycle mem_req=1 && !mem_ready. If it reaches MEM_TIMEOUT (nonzero) → TRAP, cause 2 from FETCH or cause 3 from MEM.
- mem_ready arriving on the same cycle the count hits the limit: ready wins.
- mem_ready while mem_req=0 is ignored.
- TRAP: all enables 0, trap=1. trap_cause holds until rst_n.

Decomposition:
- Package rv32i_pkg: opcode constants, ALU code constants (ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 0111, SLT 1000, SLTU 1001, PASSB 1111), state encoding, pc_sel/wb_sel/trap_cause encodings.
- One sub-module, rv32i_alu_dec: combinational opcode/funct3/funct7[5] → alu_ctrl.

Test Plan:
- Reset, mem_ready=1, instr=0x00500093 (ADDI x1,x0,5) → states RESET, FETCH, DECODE, EXEC, WB. In WB: reg_we=1, alu_src_b=1, alu_ctrl=0010, wb_sel=0, pc_we=1, pc_sel=0.
- instr=0x40208133 (SUB x2,x1,x2) → EXEC alu_ctrl=0110, alu_src_b=0. instr=0x00100013 (ADDI x0) → reg_we=0 in WB.
- instr=0x00000463 (BEQ): alu_zero=1 gives pc_sel=1, pc_we=1 in EXEC; alu_zero=0 gives pc_sel=0. reg_we is never asserted; next state FETCH.
- instr=0x0000a183 (LW), mem_ready low 3 cycles in MEM → mem_req=1, mem_addr_sel=1 for 4 cycles, then WB with wb_sel=1, reg_we=1. SW 0x0020a023 → mem_we=1, no WB state.
- instr=0x00000000 → after DECODE, trap=1, trap_cause=1. No further mem_req until rst_n pulses low.
- MEM_TIMEOUT=8, mem_ready=0 in FETCH → trap, trap_cause=2 after 8 wait cycles. Separately, rst_n low mid-MEM → mem_req=0 in the same cycle; state_dbg=RESET.
